// File: rtl/am_mod_pkg.sv
// am_mod_pkg -- shared types and helpers for the AM modulator / NCO.
//   am_mode_e : modulation mode encoding (mode_in)
//   sat_s     : clamp a wide signed value into a w-bit signed range
//   lut_depth : quarter-wave sine table depth for a given lookup address width
package am_mod_pkg;

  typedef enum logic [1:0] {
    AM_DSBSC   = 2'd0,
    AM_DSBFC   = 2'd1,
    AM_BYPASS  = 2'd2,
    AM_CARRIER = 2'd3
  } am_mode_e;

  // Result is still 64 bits wide; the caller truncates to w bits.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                               input int unsigned w);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    if (v > mx)      return mx;
    else if (v < mn) return mn;
    else             return v;
  endfunction

  // N/4 + 1 points cover 0..pi/2 inclusive.
  function automatic int lut_depth(input int addr_w);
    return (1 << (addr_w - 2)) + 1;
  endfunction

endpackage

// File: rtl/nco_sine.sv
// nco_sine -- phase accumulator with quarter-wave sine lookup.
//   clk, rst_n : clock, async active-low reset
//   en         : pipeline enable; address and read registers hold when low
//   advance    : phase += inc on this edge
//   clear      : phase := 0 on this edge (wins over advance)
//   inc        : phase increment
//   sine       : signed sine sample, read register one cycle behind the
//                folded-address register (two edges after the phase is used)
module nco_sine
  import am_mod_pkg::*;
#(
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 10,
  parameter int LO_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   advance,
  input  logic                   clear,
  input  logic [PHASE_W-1:0]     inc,
  output logic signed [LO_W-1:0] sine
);

  localparam int N    = 1 << LUT_ADDR_W;
  localparam int Q    = N / 4;
  localparam int NLUT = lut_depth(LUT_ADDR_W);

  function automatic int lut_val(input int i);
    real a;
    a = ((2.0 ** (LO_W - 1)) - 1.0) *
        $sin(2.0 * 3.14159265358979323846 * real'(i) / real'(N));
    return $rtoi(a + 0.5);  // all entries are non-negative
  endfunction

  logic [LO_W-1:0] lut [NLUT];
  for (genvar i = 0; i < NLUT; i++) begin : g_lut
    assign lut[i] = LO_W'(lut_val(i));
  end

  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [LUT_ADDR_W-2:0]   addr_q, addr_d;   // 0..Q, one bit wider than k
  logic                    neg_q, neg_d;
  logic signed [LO_W-1:0]  sine_q, sine_d;
  logic [LUT_ADDR_W-1:0]   idx;
  logic [1:0]              quad;
  logic [LUT_ADDR_W-3:0]   k;

  always_comb begin
    idx  = phase_q[PHASE_W-1 -: LUT_ADDR_W];
    quad = idx[LUT_ADDR_W-1 -: 2];
    k    = idx[LUT_ADDR_W-3:0];

    phase_d = phase_q;
    if (clear)        phase_d = '0;
    else if (advance) phase_d = phase_q + inc;

    addr_d = addr_q;
    neg_d  = neg_q;
    sine_d = sine_q;
    if (en) begin
      // odd quadrants run the table backwards, upper half-cycle negates
      addr_d = quad[0] ? (LUT_ADDR_W-1)'(Q) - {1'b0, k} : {1'b0, k};
      neg_d  = quad[1];
      sine_d = neg_q ? $signed(-lut[addr_q]) : $signed(lut[addr_q]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      addr_q  <= '0;
      neg_q   <= 1'b0;
      sine_q  <= '0;
    end else begin
      phase_q <= phase_d;
      addr_q  <= addr_d;
      neg_q   <= neg_d;
      sine_q  <= sine_d;
    end
  end

  assign sine = sine_q;

endmodule

// File: rtl/am_mod_nco.sv
// am_mod_nco -- AXI-Stream amplitude modulator with integrated sine NCO.
// 3-stage pipeline (S1 capture/address, S2 LUT read/operand, S3 multiply)
// with a single global enable so backpressure freezes every stage.
//   s00_axis_*     : baseband input stream (tdata signed)
//   m00_axis_*     : modulated output stream, tlast/tstrb delayed alongside
//   phase_inc_in   : phase step per accepted sample
//   mode_in        : 0 DSB-SC, 1 DSB-FC, 2 bypass, 3 carrier-only
//   carrier_lvl_in : signed offset added to x in DSB-FC
//   phase_clr_in   : synchronous phase clear
// Build option: define AM_MOD_ROUND_EN to round half up before the
// product shift; otherwise the shift truncates toward -inf.
module am_mod_nco
  import am_mod_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 16,
  parameter int LO_W               = 16,
  parameter int PHASE_W            = 32,
  parameter int LUT_ADDR_W         = 10
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,
  input  logic                            s00_axis_tvalid,
  input  logic                            s00_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                            s00_axis_tready,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tvalid,
  output logic                            m00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  input  logic [PHASE_W-1:0]              phase_inc_in,
  input  logic [1:0]                      mode_in,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   carrier_lvl_in,
  input  logic                            phase_clr_in
);

  localparam int W      = C_AXIS_TDATA_WIDTH;
  localparam int SW     = W / 8;
  localparam int P      = W + LO_W;
  localparam int STAGES = 3;

  logic en, accept;
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;

  // S1
  logic signed [W-1:0] x1_q, x1_d, lvl1_q, lvl1_d;
  am_mode_e            mode1_q, mode1_d;
  logic                last1_q, last1_d;
  logic [SW-1:0]       strb1_q, strb1_d;
  // S2
  logic signed [W-1:0] m2_q, m2_d;
  logic                byp2_q, byp2_d, last2_q, last2_d;
  logic [SW-1:0]       strb2_q, strb2_d;
  // S3
  logic [W-1:0]        data3_q, data3_d;
  logic                last3_q, last3_d;
  logic [SW-1:0]       strb3_q, strb3_d;

  logic signed [LO_W-1:0] lo;
  logic signed [P-1:0]    prod, prod_r, shifted;

  assign en              = !vld_pipe_q[STAGES] || m00_axis_tready;
  assign accept          = s00_axis_tvalid && en;
  assign s00_axis_tready = en;

  // Address register (S1) and read register (S2) live inside the NCO.
  nco_sine #(
    .PHASE_W   (PHASE_W),
    .LUT_ADDR_W(LUT_ADDR_W),
    .LO_W      (LO_W)
  ) u_nco (
    .clk    (s00_axis_aclk),
    .rst_n  (s00_axis_aresetn),
    .en     (en),
    .advance(accept),
    .clear  (phase_clr_in),
    .inc    (phase_inc_in),
    .sine   (lo)
  );

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    x1_d = x1_q;  lvl1_d = lvl1_q;  mode1_d = mode1_q;
    last1_d = last1_q;  strb1_d = strb1_q;
    m2_d = m2_q;  byp2_d = byp2_q;  last2_d = last2_q;  strb2_d = strb2_q;
    data3_d = data3_q;  last3_d = last3_q;  strb3_d = strb3_q;

    prod = m2_q * lo;
`ifdef AM_MOD_ROUND_EN
    prod_r = prod + $signed(P'(1 << (LO_W - 2)));
`else
    prod_r = prod;
`endif
    shifted = prod_r >>> (LO_W - 1);

    if (en) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], accept};
      // S1
      x1_d    = s00_axis_tdata;
      lvl1_d  = carrier_lvl_in;
      mode1_d = am_mode_e'(mode_in);
      last1_d = s00_axis_tlast;
      strb1_d = s00_axis_tstrb;
      // S2
      case (mode1_q)
        AM_DSBFC:   m2_d = W'(sat_s(64'(x1_q) + 64'(lvl1_q), W));
        AM_CARRIER: m2_d = {1'b0, {(W-1){1'b1}}};
        default:    m2_d = x1_q;  // DSB-SC, and bypass carries x unchanged
      endcase
      byp2_d  = (mode1_q == AM_BYPASS);
      last2_d = last1_q;
      strb2_d = strb1_q;
      // S3
      data3_d = byp2_q ? m2_q : W'(shifted);
      last3_d = last2_q;
      strb3_d = strb2_q;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      vld_pipe_q <= '0;
      x1_q <= '0;  lvl1_q <= '0;  mode1_q <= AM_DSBSC;
      last1_q <= 1'b0;  strb1_q <= '0;
      m2_q <= '0;  byp2_q <= 1'b0;  last2_q <= 1'b0;  strb2_q <= '0;
      data3_q <= '0;  last3_q <= 1'b0;  strb3_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      x1_q <= x1_d;  lvl1_q <= lvl1_d;  mode1_q <= mode1_d;
      last1_q <= last1_d;  strb1_q <= strb1_d;
      m2_q <= m2_d;  byp2_q <= byp2_d;  last2_q <= last2_d;  strb2_q <= strb2_d;
      data3_q <= data3_d;  last3_q <= last3_d;  strb3_q <= strb3_d;
    end
  end

  assign m00_axis_tvalid = vld_pipe_q[STAGES];
  assign m00_axis_tdata  = data3_q;
  assign m00_axis_tlast  = last3_q;
  assign m00_axis_tstrb  = strb3_q;

endmodule

// File: tb/tb_am_mod_nco.sv
module tb_am_mod_nco;

`ifdef AM_MOD_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_tvalid, s_tlast, s_tready, m_tready, m_tvalid, m_tlast, clr;
  logic [15:0] s_tdata, m_tdata, lvl;
  logic [1:0]  s_tstrb, m_tstrb, mode;
  logic [31:0] inc;

  always #5 clk = ~clk;

  am_mod_nco dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rstn),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
    .s00_axis_tready(s_tready), .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tlast(m_tlast),
    .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
    .phase_inc_in(inc), .mode_in(mode), .carrier_lvl_in(lvl),
    .phase_clr_in(clr)
  );

  typedef struct {
    logic [1:0]  mode;
    int          x;
    int          lvl;
    logic [31:0] inc;
    logic        clr;
    logic        last;
    logic [1:0]  strb;
    int          exp;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic [1:0]  s;
  } beat_t;

  vec_t  vecs[$];
  beat_t q[$];
  int    checks = 0, errors = 0;

  always @(negedge clk)
    if (rstn && m_tvalid && m_tready) q.push_back('{m_tdata, m_tlast, m_tstrb});

  function automatic int r(input int trunc_v, input int round_v);
    return RND ? round_v : trunc_v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int md, input int x, input int lv, input logic [31:0] ph,
                     input logic c, input logic l, input logic [1:0] s, input int e);
    vecs.push_back('{md[1:0], x, lv, ph, c, l, s, e});
  endtask

  task automatic clr_phase();
    s_tvalid = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (q.size() < n && t < 30) begin @(posedge clk); #1; t++; end
  endtask

  task automatic run_group(input int lo, input int hi, input string nm);
    int n = hi - lo + 1;
    clr_phase();
    q.delete();
    for (int i = lo; i <= hi; i++) begin
      s_tvalid = 1'b1; s_tdata = 16'(vecs[i].x); lvl = 16'(vecs[i].lvl);
      mode = vecs[i].mode; inc = vecs[i].inc; clr = vecs[i].clr;
      s_tlast = vecs[i].last; s_tstrb = vecs[i].strb;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; clr = 1'b0; s_tlast = 1'b0;
    wait_beats(n);
    chk({nm, " count"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk($sformatf("%s[%0d] data", nm, i), $signed(q[i].d), vecs[lo+i].exp);
      chk($sformatf("%s[%0d] last", nm, i), q[i].l, vecs[lo+i].last);
      chk($sformatf("%s[%0d] strb", nm, i), q[i].s, vecs[lo+i].strb);
    end
  endtask

  initial begin
    int exp8[8];
    int idx, cyc;
    logic acc;

    // A: DSB-SC, quarter-cycle steps
    add(0, 16384, 0, 32'h4000_0000, 0, 0, 3, 0);
    add(0, 16384, 0, 32'h4000_0000, 0, 0, 3, r(16383, 16384));
    add(0, 16384, 0, 32'h4000_0000, 0, 0, 3, 0);
    add(0, 16384, 0, 32'h4000_0000, 0, 1, 3, r(-16384, -16383));
    // B: DSB-FC with positive saturation
    add(1, 30000, 10000, 32'h4000_0000, 0, 0, 1, 0);
    add(1, 30000, 10000, 32'h4000_0000, 0, 0, 1, 32766);
    add(1, 30000, 10000, 32'h4000_0000, 0, 0, 1, 0);
    add(1, 30000, 10000, 32'h4000_0000, 0, 0, 1, r(-32767, -32766));
    // C: bypass, tlast on 5th
    add(2, 1234, 0, 32'h4000_0000, 0, 0, 3, 1234);
    add(2, -5, 0, 32'h4000_0000, 0, 0, 1, -5);
    add(2, 32767, 0, 32'h4000_0000, 0, 0, 2, 32767);
    add(2, -32768, 0, 32'h4000_0000, 0, 0, 3, -32768);
    add(2, 77, 0, 32'h4000_0000, 0, 1, 0, 77);
    // D: eighth-cycle steps, mixed modes per sample
    add(3, 0, 0, 32'h2000_0000, 0, 0, 3, 0);
    add(3, 0, 0, 32'h2000_0000, 0, 0, 3, 23169);
    add(3, 0, 0, 32'h2000_0000, 0, 0, 3, 32766);
    add(3, 0, 0, 32'h2000_0000, 0, 0, 3, 23169);
    add(3, 0, 0, 32'h2000_0000, 0, 0, 3, 0);
    add(0, -32768, 0, 32'h2000_0000, 0, 0, 3, 23170);
    add(1, -30000, -10000, 32'h2000_0000, 0, 1, 3, 32767);
    // E: phase clear together with the 4th accept
    add(3, 0, 0, 32'h4000_0000, 0, 0, 3, 0);
    add(3, 0, 0, 32'h4000_0000, 0, 0, 3, 32766);
    add(3, 0, 0, 32'h4000_0000, 0, 0, 3, 0);
    add(3, 0, 0, 32'h4000_0000, 1, 0, 3, r(-32767, -32766));
    add(3, 0, 0, 32'h4000_0000, 0, 1, 3, 0);

    exp8 = '{0, 23169, 32766, 23169, 0, r(-23170, -23169), r(-32767, -32766), r(-23170, -23169)};

    s_tvalid = 0; s_tlast = 0; s_tdata = 0; s_tstrb = 0; m_tready = 1;
    clr = 0; lvl = 0; mode = 0; inc = 0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("rst tvalid", m_tvalid, 0);
    chk("rst tdata", m_tdata, 0);
    chk("rst tlast", m_tlast, 0);
    chk("rst tstrb", m_tstrb, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst tready", s_tready, 1);

    // latency: accept, then two empty-output edges, then data
    clr_phase();
    mode = 2; s_tdata = 16'd555; s_tvalid = 1'b1;
    @(posedge clk); #1 s_tvalid = 1'b0;
    chk("lat edge1 tvalid", m_tvalid, 0);
    @(posedge clk); #1;
    chk("lat edge2 tvalid", m_tvalid, 0);
    @(posedge clk); #1;
    chk("lat edge3 tvalid", m_tvalid, 1);
    chk("lat edge3 tdata", m_tdata, 555);
    repeat (2) @(posedge clk);
    #1;

    run_group(0, 3, "dsbsc");
    run_group(4, 7, "dsbfc");
    run_group(8, 12, "bypass");
    run_group(13, 19, "mixed");
    run_group(20, 24, "clr");

    // backpressure: 5 stalled cycles with tvalid held high
    clr_phase();
    q.delete();
    mode = 3; inc = 32'h2000_0000;
    idx = 0; cyc = 0;
    while (idx < 12 && cyc < 100) begin
      s_tvalid = 1'b1; s_tdata = 16'(idx); s_tlast = (idx == 11); s_tstrb = 2'(idx);
      m_tready = !(cyc >= 6 && cyc < 11);
      @(negedge clk);
      acc = s_tready;
      if (!m_tready) begin
        chk("bp s_tready", s_tready, 0);
        chk("bp m_tvalid", m_tvalid, 1);
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    wait_beats(12);
    chk("bp count", q.size(), 12);
    for (int i = 0; i < 12 && i < q.size(); i++) begin
      chk($sformatf("bp[%0d] data", i), $signed(q[i].d), exp8[i % 8]);
      chk($sformatf("bp[%0d] strb", i), q[i].s, i % 4);
      chk($sformatf("bp[%0d] last", i), q[i].l, i == 11);
    end

    // asynchronous reset with samples in flight
    clr_phase();
    mode = 3; inc = 32'h4000_0000;
    s_tvalid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    s_tvalid = 1'b0;
    chk("mid pre-rst tvalid", m_tvalid, 1);
    #1 rstn = 1'b0;
    #1;
    chk("mid rst tvalid", m_tvalid, 0);
    chk("mid rst tdata", m_tdata, 0);
    @(posedge clk); #1 rstn = 1'b1;
    q.delete();
    chk("mid post-rst tready", s_tready, 1);
    s_tvalid = 1'b1;
    @(posedge clk); #1 s_tvalid = 1'b0;
    wait_beats(1);
    chk("mid post-rst count", q.size(), 1);
    if (q.size() > 0) chk("mid post-rst data", $signed(q[0].d), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
